// File: rtl/sync_fifo_pkg.sv
// Shared constants and pointer helper for the sync_fifo_v2 family.
package sync_fifo_pkg;

  localparam int FWFT_OFF      = 0;
  localparam int FWFT_ON       = 1;
  localparam int DEFAULT_DEPTH = 8;
  localparam int DEFAULT_WIDTH = 8;

  // Modulo-depth increment; depth need not be a power of two.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    if (ptr >= depth - 32'd1) begin
      return 32'd0;
    end else begin
      return ptr + 32'd1;
    end
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple storage array: one synchronous write port, one asynchronous read port, no reset.
module sync_fifo_ram #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_v2.sv
// Synchronous FIFO with registered or first-word-fall-through read, status flags and sticky errors.
module sync_fifo_v2
  import sync_fifo_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_DEPTH,
  parameter int DATA_WIDTH = DEFAULT_WIDTH,
  parameter int FWFT       = FWFT_OFF,
  localparam int CNT_WIDTH = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid_s,
  input  logic [DATA_WIDTH-1:0] i_datain,
  output logic                  o_ready_s,
  input  logic                  i_ready_m,
  output logic                  o_valid_m,
  output logic [DATA_WIDTH-1:0] o_dataout,
  input  logic [CNT_WIDTH-1:0]  i_almostfull_lvl,
  input  logic [CNT_WIDTH-1:0]  i_almostempty_lvl,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_almostfull,
  output logic                  o_almostempty,
  output logic [CNT_WIDTH-1:0]  o_count,
  output logic                  o_overflow,
  output logic                  o_underflow,
  input  logic                  i_clr_err
);

  localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(FIFO_DEPTH);

  logic [PTR_WIDTH-1:0]  wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic [CNT_WIDTH-1:0]  count_r, count_nxt_s;
  logic [DATA_WIDTH-1:0] dout_r, head_s;
  logic                  valid_r, overflow_r, underflow_r;
  logic                  full_s, empty_s, push_s, pop_s, we_s;

  assign full_s  = (count_r == DEPTH_C);
  assign empty_s = (count_r == {CNT_WIDTH{1'b0}});
  // Full blocks the write and empty blocks the read, so no bypass path exists.
  assign push_s  = i_valid_s & ~full_s;
  assign pop_s   = i_ready_m & ~empty_s;
  assign we_s    = push_s & ~i_rst;

  assign wr_ptr_nxt_s = PTR_WIDTH'(wrap_inc(32'(wr_ptr_r), FIFO_DEPTH));
  assign rd_ptr_nxt_s = PTR_WIDTH'(wrap_inc(32'(rd_ptr_r), FIFO_DEPTH));

  sync_fifo_ram #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (i_clk),
    .we    (we_s),
    .waddr (wr_ptr_r),
    .wdata (i_datain),
    .raddr (rd_ptr_r),
    .rdata (head_s)
  );

  // occupancy next-state
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_WIDTH'(1);
      2'b01:   count_nxt_s = count_r - CNT_WIDTH'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // pointers, count, registered read data and sticky errors
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_r    <= {PTR_WIDTH{1'b0}};
      rd_ptr_r    <= {PTR_WIDTH{1'b0}};
      count_r     <= {CNT_WIDTH{1'b0}};
      dout_r      <= {DATA_WIDTH{1'b0}};
      valid_r     <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_nxt_s;
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_nxt_s;
        dout_r   <= head_s;
      end
      count_r     <= count_nxt_s;
      valid_r     <= pop_s;
      // a new error outranks a clear in the same cycle
      overflow_r  <= (i_valid_s & full_s)  | (overflow_r  & ~i_clr_err);
      underflow_r <= (i_ready_m & empty_s) | (underflow_r & ~i_clr_err);
    end
  end

  generate
    if (FWFT == FWFT_ON) begin : g_fwft
      assign o_valid_m = ~empty_s;
      assign o_dataout = empty_s ? {DATA_WIDTH{1'b0}} : head_s;
    end else begin : g_reg
      assign o_valid_m = valid_r;
      assign o_dataout = dout_r;
    end
  endgenerate

  assign o_ready_s     = ~full_s;
  assign o_full        = full_s;
  assign o_empty       = empty_s;
  assign o_almostfull  = (DEPTH_C - count_r) <= i_almostfull_lvl;
  assign o_almostempty = count_r <= i_almostempty_lvl;
  assign o_count       = count_r;
  assign o_overflow    = overflow_r;
  assign o_underflow   = underflow_r;

endmodule

// File: tb/tb_sync_fifo_v2.sv
// Bench: three FIFO instances (depth 8 registered, depth 8 FWFT, depth 5 registered) on shared stimulus.
module tb_sync_fifo_v2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vin = 1'b0;
  logic [7:0] din = 8'h00;
  logic       rdy = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] afl = 4'd2;
  logic [3:0] ael = 4'd2;

  logic       s_ready [3];
  logic       m_valid [3];
  logic [7:0] m_data  [3];
  logic       f_full  [3];
  logic       f_empty [3];
  logic       f_af    [3];
  logic       f_ae    [3];
  logic       f_ovf   [3];
  logic       f_unf   [3];
  logic [3:0] cnt0, cnt1;
  logic [2:0] cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo_v2 #(.FIFO_DEPTH(8), .DATA_WIDTH(8), .FWFT(0)) u0 (
    .i_clk(clk), .i_rst(rst), .i_valid_s(vin), .i_datain(din), .o_ready_s(s_ready[0]),
    .i_ready_m(rdy), .o_valid_m(m_valid[0]), .o_dataout(m_data[0]),
    .i_almostfull_lvl(afl), .i_almostempty_lvl(ael),
    .o_full(f_full[0]), .o_empty(f_empty[0]), .o_almostfull(f_af[0]), .o_almostempty(f_ae[0]),
    .o_count(cnt0), .o_overflow(f_ovf[0]), .o_underflow(f_unf[0]), .i_clr_err(clr));

  sync_fifo_v2 #(.FIFO_DEPTH(8), .DATA_WIDTH(8), .FWFT(1)) u1 (
    .i_clk(clk), .i_rst(rst), .i_valid_s(vin), .i_datain(din), .o_ready_s(s_ready[1]),
    .i_ready_m(rdy), .o_valid_m(m_valid[1]), .o_dataout(m_data[1]),
    .i_almostfull_lvl(afl), .i_almostempty_lvl(ael),
    .o_full(f_full[1]), .o_empty(f_empty[1]), .o_almostfull(f_af[1]), .o_almostempty(f_ae[1]),
    .o_count(cnt1), .o_overflow(f_ovf[1]), .o_underflow(f_unf[1]), .i_clr_err(clr));

  sync_fifo_v2 #(.FIFO_DEPTH(5), .DATA_WIDTH(8), .FWFT(0)) u2 (
    .i_clk(clk), .i_rst(rst), .i_valid_s(vin), .i_datain(din), .o_ready_s(s_ready[2]),
    .i_ready_m(rdy), .o_valid_m(m_valid[2]), .o_dataout(m_data[2]),
    .i_almostfull_lvl(afl[2:0]), .i_almostempty_lvl(ael[2:0]),
    .o_full(f_full[2]), .o_empty(f_empty[2]), .o_almostfull(f_af[2]), .o_almostempty(f_ae[2]),
    .o_count(cnt2), .o_overflow(f_ovf[2]), .o_underflow(f_unf[2]), .i_clr_err(clr));

  // Reference model: a queue per instance plus the registered read/error state.
  int         m_depth [3] = '{8, 8, 5};
  int         m_fwft  [3] = '{0, 1, 0};
  logic [7:0] mq [3][$];
  logic [7:0] m_dout [3];
  logic       m_vld  [3];
  logic       m_ovf  [3];
  logic       m_unf  [3];
  bit         model_live = 1'b0;

  task automatic cmp(input string nm, input int k, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[u%0d] got %0h want %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        mq[k].delete();
        m_dout[k] <= 8'h00;
        m_vld[k]  <= 1'b0;
        m_ovf[k]  <= 1'b0;
        m_unf[k]  <= 1'b0;
      end else begin
        automatic int sz = mq[k].size();
        automatic bit fl = (sz == m_depth[k]);
        automatic bit em = (sz == 0);
        m_ovf[k] <= (m_ovf[k] && !clr) || (vin && fl);
        m_unf[k] <= (m_unf[k] && !clr) || (rdy && em);
        m_vld[k] <= 1'b0;
        if (rdy && !em) begin
          automatic logic [7:0] w = mq[k].pop_front();
          if (m_fwft[k] == 0) begin
            m_dout[k] <= w;
            m_vld[k]  <= 1'b1;
          end
        end
        if (vin && !fl) mq[k].push_back(din);
      end
    end
    if (rst) model_live <= 1'b1;
  end

  // Every-cycle comparison of all three instances against the model.
  always @(negedge clk) begin
    if (model_live) begin
      for (int k = 0; k < 3; k++) begin
        automatic int sz = mq[k].size();
        automatic int cnt = (k == 0) ? int'(cnt0) : (k == 1) ? int'(cnt1) : int'(cnt2);
        cmp("count", k, cnt, sz);
        cmp("full", k, f_full[k], sz == m_depth[k]);
        cmp("empty", k, f_empty[k], sz == 0);
        cmp("ready", k, s_ready[k], sz != m_depth[k]);
        cmp("almostfull", k, f_af[k], (m_depth[k] - sz) <= int'(afl));
        cmp("almostempty", k, f_ae[k], sz <= int'(ael));
        cmp("overflow", k, f_ovf[k], m_ovf[k]);
        cmp("underflow", k, f_unf[k], m_unf[k]);
        if (m_fwft[k] == 1) begin
          cmp("valid", k, m_valid[k], sz != 0);
          if (sz != 0) cmp("dout", k, m_data[k], mq[k][0]);
        end else begin
          cmp("valid", k, m_valid[k], m_vld[k]);
          cmp("dout", k, m_data[k], m_dout[k]);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] d, input logic r, input logic c);
    vin = v; din = d; rdy = r; clr = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    int j;
    // reset
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    cmp("rst_count", 0, cnt0, 0);
    cmp("rst_empty", 0, f_empty[0], 1);
    cmp("rst_ready", 0, s_ready[0], 1);
    cmp("rst_dout", 0, m_data[0], 8'h00);

    // fill with 0x01..0x08; almostfull first high at count 6
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 8'(k), 1'b0, 1'b0);
      cmp("fill_af", 0, f_af[0], k >= 6);
    end
    cmp("fill_full", 0, f_full[0], 1);
    cmp("fill_count", 0, cnt0, 8);
    drive(1'b1, 8'h09, 1'b0, 1'b0);
    cmp("ovf_set", 0, f_ovf[0], 1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    cmp("ovf_clr", 0, f_ovf[0], 0);

    // full with push and pop together: only the pop happens
    drive(1'b1, 8'h55, 1'b1, 1'b0);
    cmp("fullpp_count", 0, cnt0, 7);
    cmp("fullpp_ovf", 0, f_ovf[0], 1);
    cmp("fullpp_dout", 0, m_data[0], 8'h01);
    for (int k = 2; k <= 8; k++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      cmp("drain_dout", 0, m_data[0], k);
    end

    // underflow, clear, clear racing a new underflow
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    cmp("unf_set", 0, f_unf[0], 1);
    cmp("unf_count", 0, cnt0, 0);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    cmp("unf_clr", 0, f_unf[0], 0);
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    cmp("unf_setwins", 0, f_unf[0], 1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);

    // single word: FWFT shows it next cycle, registered mode after the pop
    drive(1'b1, 8'hA5, 1'b0, 1'b0);
    cmp("fwft_valid", 1, m_valid[1], 1);
    cmp("fwft_dout", 1, m_data[1], 8'hA5);
    cmp("reg_novalid", 0, m_valid[0], 0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    cmp("reg_dout", 0, m_data[0], 8'hA5);
    cmp("reg_valid", 0, m_valid[0], 1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    cmp("reg_pulse", 0, m_valid[0], 0);
    cmp("reg_hold", 0, m_data[0], 8'hA5);

    // count 4 with push and pop together
    for (int k = 0; k < 4; k++) drive(1'b1, 8'(8'h10 + k), 1'b0, 1'b0);
    drive(1'b1, 8'h14, 1'b1, 1'b0);
    cmp("midpp_count", 0, cnt0, 4);
    cmp("midpp_dout", 0, m_data[0], 8'h10);
    afl = 4'd4; ael = 4'd3;
    #1;
    cmp("thr_af", 0, f_af[0], 1);
    cmp("thr_ae", 0, f_ae[0], 0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    afl = 4'd2; ael = 4'd2;
    for (int k = 1; k <= 4; k++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      cmp("midpp_order", 0, m_data[0], 8'h10 + k);
    end

    // depth 5: 12 pushes interleaved with pops, wrapping pointers twice
    j = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 8'(8'h30 + i), (i % 3) != 0, 1'b0);
      if ((i % 3) != 0) begin
        cmp("wrap_dout", 2, m_data[2], 8'h30 + j);
        j++;
      end
    end
    cmp("wrap_count", 2, cnt2, 4);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      cmp("wrap_drain", 2, m_data[2], 8'h38 + k);
    end
    cmp("wrap_empty", 2, f_empty[2], 1);

    // reset mid-stream discards data and a same-cycle push
    for (int k = 0; k < 3; k++) drive(1'b1, 8'(8'h60 + k), 1'b0, 1'b0);
    rst = 1'b1;
    drive(1'b1, 8'h77, 1'b0, 1'b0);
    rst = 1'b0;
    cmp("midrst_count", 2, cnt2, 0);
    cmp("midrst_empty", 2, f_empty[2], 1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    cmp("midrst_still_empty", 0, f_empty[0], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
